pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC and address width.
REQ-002 SHALL have parameter RESET_VECTOR, default 0: PC value loaded on reset.
REQ-003 SHALL have parameter STEP, default 4: PC increment per issued fetch.
REQ-004 SHALL have parameter DEPTH, default 2, range 1..8: maximum in-flight fetches plus buffered results.
REQ-005 SHALL have port clock  in  1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-007 SHALL have ports req_valid out 1, req_ready in 1, req_addr out XLEN: fetch request handshake to the bus.
REQ-008 SHALL have ports rsp_valid in 1, rsp_data in 32: in-order fetch response; no backpressure.
REQ-009 SHALL have ports out_valid out 1, out_ready in 1, out_inst out 32, out_addr out XLEN: fetched pair to decode.
REQ-010 SHALL have ports redirect_valid in 1, redirect_target in XLEN: jump/branch redirect from execute.
REQ-011 SHALL have port fault out 1: misaligned-redirect flag; tied 0 without MISALIGN_TRAP_EN.

Function
REQ-012 SHALL hold pc, an occupancy count (0..DEPTH), an in-order pending-address FIFO and a completed-pair FIFO, each DEPTH deep.
REQ-013 SHALL assert req_valid when state is RUN and occupancy < DEPTH; req_addr SHALL equal pc.
REQ-014 SHALL on req_valid&&req_ready push pc into the pending FIFO, set pc <= pc+STEP (mod 2^XLEN, wraps silently) and increment occupancy.
REQ-015 SHALL on rsp_valid pop the oldest pending address; if drop_count=0, push {rsp_data, address} to the completed FIFO; otherwise discard and decrement drop_count.
REQ-016 SHALL present the completed-FIFO head on out_inst/out_addr with out_valid, one cycle after the accepting rsp_valid at the earliest.
REQ-017 SHALL decrement occupancy on out_valid&&out_ready and on each discarded response.
REQ-018 SHALL ignore rsp_valid when the pending FIFO is empty (protocol error; no state change).
REQ-019 SHALL on redirect_valid: set pc <= redirect_target; flush the completed FIFO except an entry handshaked that same cycle; set drop_count = pending entries after that cycle's request and response handshakes.
REQ-020 SHALL count a request accepted in the redirect cycle as stale and drop its response.
REQ-021 SHALL give redirect priority over the PC increment when both occur in the same cycle.
REQ-022 SHALL implement states RUN, DRAIN, HALT: RUN->DRAIN on redirect with drop_count>0; DRAIN->RUN when drop_count reaches 0; requests SHALL also issue in DRAIN.
REQ-023 SHALL treat a redirect in DRAIN as adding the new pending entries to drop_count.
REQ-024 SHALL never exceed DEPTH occupancy; full: req_valid=0; empty: out_valid=0.

Reset
REQ-025 SHALL on reset asynchronously set pc=RESET_VECTOR, state=RUN, occupancy=0, drop_count=0, FIFOs empty, req_valid=0, out_valid=0, fault=0.
REQ-026 SHALL discard all in-flight fetches on reset mid-operation; responses arriving after reset are ignored per REQ-018.
REQ-027 SHALL issue the first request (req_addr=RESET_VECTOR) in the first clock after reset deasserts.

Configuration
REQ-028 SHALL, with PC_SEQ_MISALIGN_TRAP_EN defined, enter HALT on redirect_target[1:0]!=0, assert fault, stop issuing, drop outstanding responses, and leave HALT only on an aligned redirect, which clears fault.
REQ-029 SHALL, without PC_SEQ_MISALIGN_TRAP_EN, force redirect_target[1:0] to 0, never enter HALT, and tie fault to 0.

Verification
REQ-030 Reset release, req_ready=1, rsp one cycle after each request -> req_addr 0x0, 0x4, 0x8; out pairs (0x0,I0), (0x4,I1) in order.
REQ-031 DEPTH=2, out_ready=0 -> exactly two requests issue, req_valid stays 0 until one out handshake.
REQ-032 Two requests outstanding, redirect to 0x100 -> both responses dropped, next out_addr 0x100, state returns to RUN.
REQ-033 Redirect coinciding with req handshake and rsp_valid -> the in-flight response is dropped, the new request is counted stale, pc=target.
REQ-034 With PC_SEQ_MISALIGN_TRAP_EN, redirect to 0x102 -> fault=1, req_valid=0; redirect to 0x200 -> fault=0, req_addr 0x200.
REQ-035 Reset asserted mid-burst -> all outputs at reset values the same cycle; req_addr 0x0 after release.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: bounded in-flight fetch tracking, in-order response pairing and redirect drain.
// Define PC_SEQ_MISALIGN_TRAP_EN to halt with fault on a misaligned redirect instead of masking it.
module pc_sequencer #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int unsigned      STEP         = 4,
  parameter int unsigned      DEPTH        = 2
) (
  input  logic            clock,
  input  logic            reset,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [31:0]     rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_addr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            fault
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW:0]   FULL = (CW+1)'(DEPTH);

  // state    | meaning
  // ST_RUN   | issuing, every pending response is kept
  // ST_DRAIN | issuing, oldest drop_q responses belong to the abandoned path
  // ST_HALT  | misaligned redirect seen: no issue, all pending responses dropped
  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   pend_cnt_q, pend_cnt_d, cmp_cnt_q, cmp_cnt_d, drop_q, drop_d;
  logic [PW-1:0]   pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
  logic [PW-1:0]   cmp_rd_q, cmp_rd_d, cmp_wr_q, cmp_wr_d;
  logic            req_valid_q, req_valid_d, fault_q, fault_d;
  logic [XLEN-1:0] pend_addr_q [DEPTH];
  logic [31:0]     cmp_inst_q  [DEPTH];
  logic [XLEN-1:0] cmp_addr_q  [DEPTH];
  logic            req_fire, rsp_fire, out_fire, keep, cmp_push, misaligned;
  logic [XLEN-1:0] target;
  logic [CW:0]     occ_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    req_fire = req_valid_q & req_ready;
    rsp_fire = rsp_valid & (pend_cnt_q != '0);
    out_fire = (cmp_cnt_q != '0) & out_ready;
    keep     = rsp_fire & (drop_q == '0);
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    target     = redirect_target;
    misaligned = (redirect_target[1:0] != 2'b00);
`else
    target     = redirect_target & ~XLEN'(3);
    misaligned = 1'b0;
`endif
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;

    pend_wr_d  = req_fire ? ptr_inc(pend_wr_q) : pend_wr_q;
    pend_rd_d  = rsp_fire ? ptr_inc(pend_rd_q) : pend_rd_q;
    pend_cnt_d = pend_cnt_q + CW'(req_fire) - CW'(rsp_fire);

    cmp_push  = keep;
    cmp_wr_d  = keep ? ptr_inc(cmp_wr_q) : cmp_wr_q;
    cmp_rd_d  = out_fire ? ptr_inc(cmp_rd_q) : cmp_rd_q;
    cmp_cnt_d = cmp_cnt_q + CW'(keep) - CW'(out_fire);

    drop_d = drop_q - CW'(rsp_fire & ~keep);

    if (req_fire) pc_d = pc_q + XLEN'(STEP);
    if (state_q == ST_DRAIN && drop_d == '0) state_d = ST_RUN;

    // Everything still pending after this cycle's handshakes is from the old path,
    // including a request accepted in this very cycle.
    if (redirect_valid) begin
      cmp_push  = 1'b0;
      cmp_wr_d  = cmp_wr_q;
      cmp_rd_d  = cmp_wr_q;
      cmp_cnt_d = '0;
      drop_d    = pend_cnt_d;
      if (misaligned) begin
        state_d = ST_HALT;
        fault_d = 1'b1;
      end else begin
        pc_d    = target;
        fault_d = 1'b0;
        state_d = (pend_cnt_d != '0) ? ST_DRAIN : ST_RUN;
      end
    end

    occ_d       = {1'b0, pend_cnt_d} + {1'b0, cmp_cnt_d};
    req_valid_d = (state_d != ST_HALT) && (occ_d < FULL);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_VECTOR;
      pend_cnt_q  <= '0;
      pend_rd_q   <= '0;
      pend_wr_q   <= '0;
      cmp_cnt_q   <= '0;
      cmp_rd_q    <= '0;
      cmp_wr_q    <= '0;
      drop_q      <= '0;
      req_valid_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_cnt_q  <= pend_cnt_d;
      pend_rd_q   <= pend_rd_d;
      pend_wr_q   <= pend_wr_d;
      cmp_cnt_q   <= cmp_cnt_d;
      cmp_rd_q    <= cmp_rd_d;
      cmp_wr_q    <= cmp_wr_d;
      drop_q      <= drop_d;
      req_valid_q <= req_valid_d;
      fault_q     <= fault_d;
    end
  end

  always_ff @(posedge clock) begin
    if (req_fire) pend_addr_q[pend_wr_q] <= pc_q;
    if (cmp_push) begin
      cmp_inst_q[cmp_wr_q] <= rsp_data;
      cmp_addr_q[cmp_wr_q] <= pend_addr_q[pend_rd_q];
    end
  end

  assign req_valid = req_valid_q;
  assign req_addr  = pc_q;
  assign out_valid = (cmp_cnt_q != '0);
  assign out_inst  = cmp_inst_q[cmp_rd_q];
  assign out_addr  = cmp_addr_q[cmp_rd_q];
  assign fault     = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand sequences and a queue-based random reference.
module tb_pc_sequencer;
  localparam int DEPTH = 2;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clock, reset;
  logic        req_valid, req_ready, rsp_valid, out_valid, out_ready, redirect_valid, fault;
  logic [31:0] req_addr, rsp_data, out_inst, out_addr, redirect_target;

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .STEP(4), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .fault(fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  bit last_fire;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: pending fetches carry a stale tag instead of a drop counter.
  typedef struct { logic [31:0] addr; bit stale; } pend_t;
  typedef struct { logic [31:0] inst; logic [31:0] addr; } pair_t;
  pend_t       m_pend[$];
  pair_t       m_done[$];
  logic [31:0] m_pc;
  bit          m_alive, m_halt, m_fault;

  function automatic bit m_rv();
    return m_alive && !m_halt && ((m_pend.size() + m_done.size()) < DEPTH);
  endfunction

  task automatic model_reset();
    m_pend.delete();
    m_done.delete();
    m_pc = 32'h0;
    m_alive = 1'b0;
    m_halt = 1'b0;
    m_fault = 1'b0;
  endtask

  task automatic model_edge(input bit rdy, input bit rv, input logic [31:0] d,
                            input bit ordy, input bit redir, input logic [31:0] tgt);
    bit rf, sf, of;
    pend_t p;
    pair_t pr;
    rf = m_rv() && rdy;
    sf = rv && (m_pend.size() > 0);
    of = (m_done.size() > 0) && ordy;
    if (of) void'(m_done.pop_front());
    if (sf) begin
      p = m_pend.pop_front();
      if (!p.stale) begin
        pr.inst = d;
        pr.addr = p.addr;
        m_done.push_back(pr);
      end
    end
    if (rf) begin
      p.addr = m_pc;
      p.stale = 1'b0;
      m_pend.push_back(p);
      m_pc = m_pc + 32'd4;
    end
    if (redir) begin
      foreach (m_pend[i]) m_pend[i].stale = 1'b1;
      m_done.delete();
      if (TRAP && tgt[1:0] != 2'b00) begin
        m_halt = 1'b1;
        m_fault = 1'b1;
      end else begin
        m_halt = 1'b0;
        m_fault = 1'b0;
        m_pc = {tgt[31:2], 2'b00};
      end
    end
    m_alive = 1'b1;
  endtask

  task automatic step(input bit rdy, input bit rv, input logic [31:0] d,
                      input bit ordy, input bit redir, input logic [31:0] tgt);
    req_ready = rdy;
    rsp_valid = rv;
    rsp_data = d;
    out_ready = ordy;
    redirect_valid = redir;
    redirect_target = tgt;
    last_fire = req_valid && rdy;
    @(posedge clock);
    model_edge(rdy, rv, d, ordy, redir, tgt);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data = '0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_model(input string tag);
    check({tag, " req_valid"}, req_valid, m_rv());
    check({tag, " req_addr"}, req_addr, m_pc);
    check({tag, " out_valid"}, out_valid, m_done.size() > 0);
    if (m_done.size() > 0) begin
      check({tag, " out_addr"}, out_addr, m_done[0].addr);
      check({tag, " out_inst"}, out_inst, m_done[0].inst);
    end
    check({tag, " fault"}, fault, m_fault);
  endtask

  typedef struct {
    bit rst; bit rdy; bit rv; logic [31:0] d; bit ordy; bit redir; logic [31:0] tgt;
    bit e_rv; logic [31:0] e_ra; bit e_ov; logic [31:0] e_oa; logic [31:0] e_oi;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL timeout: run did not complete, limit 500000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [14];
    int   issued;
    logic [31:0] tgt;

    //            rst rdy rv data          ordy redir target      e_rv e_ra          e_ov e_oa          e_oi
    tbl[0]  = '{1, 1, 0, 32'h0,         1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0};
    tbl[1]  = '{0, 1, 0, 32'h0,         1, 0, 32'h0,        1, 32'h4,        0, 32'h0,        32'h0};
    tbl[2]  = '{0, 1, 1, 32'h1111_0000, 1, 0, 32'h0,        0, 32'h8,        1, 32'h0,        32'h1111_0000};
    tbl[3]  = '{0, 1, 1, 32'h2222_0001, 1, 0, 32'h0,        1, 32'h8,        1, 32'h4,        32'h2222_0001};
    tbl[4]  = '{0, 0, 0, 32'h0,         1, 0, 32'h0,        1, 32'h8,        0, 32'h0,        32'h0};
    tbl[5]  = '{1, 1, 0, 32'h0,         0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0};
    tbl[6]  = '{0, 1, 0, 32'h0,         0, 0, 32'h0,        1, 32'h4,        0, 32'h0,        32'h0};
    tbl[7]  = '{0, 1, 0, 32'h0,         0, 0, 32'h0,        0, 32'h8,        0, 32'h0,        32'h0};
    tbl[8]  = '{0, 0, 0, 32'h0,         0, 1, 32'h100,      0, 32'h100,      0, 32'h0,        32'h0};
    tbl[9]  = '{0, 0, 1, 32'hDEAD_0001, 0, 0, 32'h0,        1, 32'h100,      0, 32'h0,        32'h0};
    tbl[10] = '{0, 1, 1, 32'hDEAD_0002, 0, 0, 32'h0,        1, 32'h104,      0, 32'h0,        32'h0};
    tbl[11] = '{0, 0, 1, 32'hCAFE_0100, 0, 0, 32'h0,        1, 32'h104,      1, 32'h100,      32'hCAFE_0100};
    tbl[12] = '{0, 0, 1, 32'hBAD0_BAD0, 0, 0, 32'h0,        1, 32'h104,      1, 32'h100,      32'hCAFE_0100};
    tbl[13] = '{0, 0, 0, 32'h0,         1, 0, 32'h0,        1, 32'h104,      0, 32'h0,        32'h0};

    reset = 1'b1;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    model_reset();
    #12;
    check("reset req_valid", req_valid, 1'b0);
    check("reset out_valid", out_valid, 1'b0);
    check("reset req_addr", req_addr, 32'h0);
    check("reset fault", fault, 1'b0);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].rst) apply_reset();
      step(tbl[i].rdy, tbl[i].rv, tbl[i].d, tbl[i].ordy, tbl[i].redir, tbl[i].tgt);
      check($sformatf("vec%0d req_valid", i), req_valid, tbl[i].e_rv);
      check($sformatf("vec%0d req_addr", i), req_addr, tbl[i].e_ra);
      check($sformatf("vec%0d out_valid", i), out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) begin
        check($sformatf("vec%0d out_addr", i), out_addr, tbl[i].e_oa);
        check($sformatf("vec%0d out_inst", i), out_inst, tbl[i].e_oi);
      end
    end

    // Full occupancy with decode stalled
    apply_reset();
    step(1, 0, 0, 0, 0, 0);
    issued = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 32'hA000_0000 + i, 0, 0, 0);
      if (last_fire) issued++;
    end
    check("full issued", issued, 2);
    check("full req_valid", req_valid, 1'b0);
    check("full out_addr", out_addr, 32'h0);
    step(0, 0, 0, 1, 0, 0);
    check("full release req_valid", req_valid, 1'b1);
    check("full release req_addr", req_addr, 32'h8);
    check("full release out_addr", out_addr, 32'h4);

    // Redirect coinciding with request and response handshakes
    apply_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 32'h5555_0000, 1, 1, 32'h40);
    check("coinc req_addr", req_addr, 32'h40);
    check("coinc req_valid", req_valid, 1'b1);
    check("coinc out_valid", out_valid, 1'b0);
    step(0, 1, 32'h5555_0004, 1, 0, 0);
    check("coinc stale out_valid", out_valid, 1'b0);
    step(1, 0, 0, 0, 0, 0);
    check("coinc new req_addr", req_addr, 32'h44);
    step(0, 1, 32'h6666_0040, 0, 0, 0);
    check("coinc out_addr", out_addr, 32'h40);
    check("coinc out_inst", out_inst, 32'h6666_0040);

    // PC wrap at the top of the address space
    apply_reset();
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    check("wrap target", req_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0, 0);
    check("wrap pc", req_addr, 32'h0);
    step(0, 1, 32'h7777_0000, 0, 0, 0);
    check("wrap out_addr", out_addr, 32'hFFFF_FFFC);

    // Misaligned redirect
    apply_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'h102);
    check("misal fault", fault, TRAP);
    check("misal req_valid", req_valid, 1'b0);
`ifndef PC_SEQ_MISALIGN_TRAP_EN
    check("misal masked addr", req_addr, 32'h100);
`endif
    step(0, 1, 32'h1, 0, 0, 0);
    step(0, 1, 32'h2, 0, 0, 0);
    check("misal drained out_valid", out_valid, 1'b0);
    check("misal drained req_valid", req_valid, !TRAP);
    step(0, 0, 0, 0, 1, 32'h200);
    check("realign fault", fault, 1'b0);
    check("realign req_valid", req_valid, 1'b1);
    check("realign req_addr", req_addr, 32'h200);

    // Reset asserted mid-burst
    apply_reset();
    for (int i = 0; i < 4; i++) step(1, 1, 32'hB000_0000 + i, 0, 0, 0);
    reset = 1'b1;
    #1;
    check("midrst req_valid", req_valid, 1'b0);
    check("midrst out_valid", out_valid, 1'b0);
    check("midrst req_addr", req_addr, 32'h0);
    check("midrst fault", fault, 1'b0);
    apply_reset();
    step(0, 0, 0, 0, 0, 0);
    check("midrst release req_valid", req_valid, 1'b1);
    check("midrst release req_addr", req_addr, 32'h0);
    step(0, 1, 32'hBAD1_BAD1, 1, 0, 0);
    check("midrst stray rsp out_valid", out_valid, 1'b0);

    // Randomized traffic against the reference
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) apply_reset();
      tgt = {20'h0, 8'($urandom_range(0, 255)), 4'h0};
      if ($urandom_range(0, 19) == 0) tgt = 32'hFFFF_FFF8;
      if ($urandom_range(0, 9) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom,
           $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 7, tgt);
      check_model($sformatf("rand%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
